// File: rtl/acca_seq_mul.sv
// Folded approximate multiplier: one HWxHW sub-multiplier reused over 4 cycles, valid/ready on both sides.
// Define ACCA_ERRMON_EN to add a parallel exact accumulator and the err output (exact minus delivered).
module acca_seq_mul #(
    parameter int WIDTH = 16,
    parameter int TRUNC = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 approx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod
`ifdef ACCA_ERRMON_EN
    ,
    output logic [2*WIDTH-1:0]   err
`endif
);

    localparam int HW = WIDTH / 2;

    // TRUNC == WIDTH wraps the extra top bit away, so the mask collapses to all zeros.
    localparam logic [WIDTH:0]   TRUNC_BIT  = (WIDTH + 1)'(1) << TRUNC;
    localparam logic [WIDTH-1:0] TRUNC_MASK = ~(TRUNC_BIT[WIDTH-1:0] - WIDTH'(1));

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
        $error("acca_seq_mul: WIDTH must be even and >= 4");
    end
    if (TRUNC < 0 || TRUNC > WIDTH) begin : g_trunc_check
        $error("acca_seq_mul: TRUNC must be in 0..WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [1:0]           r_cnt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_approx;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_prod;
    logic                 r_out_valid;

    logic                 w_in_ready;
    logic                 w_accept;
    logic [HW-1:0]        w_op_x;
    logic [HW-1:0]        w_op_y;
    logic [WIDTH-1:0]     w_pp_exact;
    logic [WIDTH-1:0]     w_pp;
    logic [2*WIDTH-1:0]   w_acc_next;

    // Places a partial product at its weight: LL<<0, LH/HL<<HW, HH<<WIDTH.
    function automatic logic [2*WIDTH-1:0] place_pp(input logic [WIDTH-1:0] pp, input logic [1:0] cnt);
        logic [2*WIDTH-1:0] ext;
        ext = {{WIDTH{1'b0}}, pp};
        case (cnt)
            2'd0:    return ext;
            2'd1,
            2'd2:    return ext << HW;
            default: return ext << WIDTH;
        endcase
    endfunction

    assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept   = in_valid && w_in_ready;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_op_x = r_a[HW-1:0];
        w_op_y = r_b[HW-1:0];
        case (r_cnt)
            2'd0: begin w_op_x = r_a[HW-1:0];     w_op_y = r_b[HW-1:0];     end
            2'd1: begin w_op_x = r_a[HW-1:0];     w_op_y = r_b[WIDTH-1:HW]; end
            2'd2: begin w_op_x = r_a[WIDTH-1:HW]; w_op_y = r_b[HW-1:0];     end
            default: begin w_op_x = r_a[WIDTH-1:HW]; w_op_y = r_b[WIDTH-1:HW]; end
        endcase
    end

    assign w_pp_exact = {{HW{1'b0}}, w_op_x} * {{HW{1'b0}}, w_op_y};
    assign w_pp       = r_approx ? (w_pp_exact & TRUNC_MASK) : w_pp_exact;
    assign w_acc_next = r_acc + place_pp(w_pp, r_cnt);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: datapath registers are reset too, so prod reads zero after reset and no stale result leaks out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 2'd0;
            r_a         <= '0;
            r_b         <= '0;
            r_approx    <= 1'b0;
            r_acc       <= '0;
            r_prod      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_approx <= approx;
                        r_acc    <= '0;
                        r_cnt    <= 2'd0;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_prod      <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Result handshake may overlap with the next accept; prod keeps its value until rewritten.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_accept) begin
                            r_a      <= a;
                            r_b      <= b;
                            r_approx <= approx;
                            r_acc    <= '0;
                            r_cnt    <= 2'd0;
                            r_state  <= S_CALC;
                        end else begin
                            r_state  <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign prod      = r_prod;

`ifdef ACCA_ERRMON_EN
    logic [2*WIDTH-1:0] r_exact_acc;
    logic [2*WIDTH-1:0] r_err;
    logic [2*WIDTH-1:0] w_exact_next;

    assign w_exact_next = r_exact_acc + place_pp(w_pp_exact, r_cnt);

    // Runs on the same schedule as the main accumulator, without truncation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exact_acc <= '0;
            r_err       <= '0;
        end else begin
            if (w_accept) begin
                r_exact_acc <= '0;
            end else if (r_state == S_CALC) begin
                r_exact_acc <= w_exact_next;
                if (r_cnt == 2'd3) begin
                    r_err <= w_exact_next - w_acc_next;
                end
            end
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_acca_seq_mul.sv
// Self-checking bench for acca_seq_mul (WIDTH=16, TRUNC=4): directed vectors plus an arithmetic scoreboard.
// Checks err as well when compiled with ACCA_ERRMON_EN.
module tb_acca_seq_mul;

    localparam int WIDTH = 16;
    localparam int TRUNC = 4;
    localparam int HW    = WIDTH / 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [WIDTH-1:0]     a = '0;
    logic [WIDTH-1:0]     b = '0;
    logic                 approx = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [2*WIDTH-1:0]   prod;
`ifdef ACCA_ERRMON_EN
    logic [2*WIDTH-1:0]   err;
`endif

    always #5 clk = ~clk;

    acca_seq_mul #(.WIDTH(WIDTH), .TRUNC(TRUNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .approx    (approx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod)
`ifdef ACCA_ERRMON_EN
        ,
        .err       (err)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: sum of the four half-by-half products at their weights, each rounded down to 2**TRUNC if approx.
    function automatic longint unsigned part(input longint unsigned u, input longint unsigned v, input logic ap);
        longint unsigned p;
        p = u * v;
        if (ap) p = p - (p % (longint'(1) << TRUNC));
        return p;
    endfunction

    function automatic logic [63:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ap);
        longint unsigned base, xl, xh, yl, yh;
        base = longint'(1) << HW;
        xl = x % base; xh = x / base;
        yl = y % base; yh = y / base;
        return part(xl, yl, ap) + (part(xl, yh, ap) + part(xh, yl, ap)) * base + part(xh, yh, ap) * base * base;
    endfunction

    typedef struct {
        logic [63:0] prod;
        logic [63:0] err;
        int          edge_no;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    logic [63:0] last_prod = '0;
    logic [63:0] last_err  = '0;
    logic        prev_ov   = 1'b0;
    bit          rand_done = 1'b0;

    always @(posedge clk) cyc++;

    // Scoreboard: samples on the falling edge what the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            last_prod = '0;
            last_err  = '0;
            prev_ov   = 1'b0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    check("prod", 64'(prod), q[0].prod);
                    if (!prev_ov) check("latency", 64'(cyc - q[0].edge_no), 64'd4);
`ifdef ACCA_ERRMON_EN
                    check("err", 64'(err), q[0].err);
`endif
                    if (out_ready) begin
                        last_prod = q[0].prod;
                        last_err  = q[0].err;
                        void'(q.pop_front());
                    end
                end
            end else begin
                check("prod_hold", 64'(prod), last_prod);
`ifdef ACCA_ERRMON_EN
                check("err_hold", 64'(err), last_err);
`endif
            end
            if (in_valid && in_ready)
                q.push_back('{model(a, b, approx), model(a, b, 1'b0) - model(a, b, approx), cyc + 1});
            prev_ov = out_valid;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge with in_valid dropped.
    task automatic drive_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ap);
        bit got;
        got = 1'b0;
        a = x; b = y; approx = ap; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
        end
        if (!got) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [63:0] exp);
        bit got;
        got = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin got = 1'b1; break; end
        end
        if (got) check(name, 64'(prod), exp);
        else check({name, "_timeout"}, 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        // Pin the reference model against hand-computed values.
        check("model_t1", model(16'hFFFF, 16'hFFFF, 1'b0), 64'hFFFE0001);
        check("model_t2", model(16'h00FF, 16'h00FF, 1'b1), 64'h0000FE00);
        check("model_t3", model(16'h0100, 16'h0100, 1'b1), 64'h0);
        check("model_t3_exact", model(16'h0100, 16'h0100, 1'b0), 64'h00010000);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_prod", 64'(prod), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // T1: latency and full-scale product.
        drive_op(16'hFFFF, 16'hFFFF, 1'b0);
        repeat (4) @(negedge clk);
        check("t1_not_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_prod", 64'(prod), 64'hFFFE0001);

        // T4: stall, then handshake and new accept on the same edge.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_stall_valid", 64'(out_valid), 64'd1);
            check("t4_stall_prod", 64'(prod), 64'hFFFE0001);
            check("t4_stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; a = 16'd2; b = 16'd3; approx = 1'b0;
        @(negedge clk);
        check("t4_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_valid_dropped", 64'(out_valid), 64'd0);
        check("t4_prod_kept", 64'(prod), 64'hFFFE0001);
        repeat (3) @(negedge clk);
        check("t4_not_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t4_valid", 64'(out_valid), 64'd1);
        check("t4_prod", 64'(prod), 64'h6);
        @(posedge clk); #1;
        out_ready = 1'b0;

        // T2: truncation of the low partial product.
        drive_op(16'h00FF, 16'h00FF, 1'b1);
        wait_result("t2_prod", 64'h0000FE00);

        // T5: reset while cnt==2 discards the transaction.
        drive_op(16'h1234, 16'h5678, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_prod", 64'(prod), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_no_partial", 64'(out_valid), 64'd0);
        end
        check("t5_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive_op(16'd3, 16'd5, 1'b0);
        wait_result("t5_prod", 64'd15);

        // T3: fully truncated high product.
        drive_op(16'h0100, 16'h0100, 1'b1);
        wait_result("t3_prod", 64'h0);
`ifdef ACCA_ERRMON_EN
        check("t3_err", 64'(err), 64'h00010000);
`endif

        // Mixed traffic with random gaps and downstream stalls; the scoreboard checks each result.
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    logic [WIDTH-1:0] x, y;
                    x = (n % 17 == 0) ? 16'hFFFF : 16'($urandom);
                    y = (n % 13 == 0) ? 16'h0000 : 16'($urandom);
                    drive_op(x, y, 1'($urandom_range(0, 1)));
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        check("drain_empty", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
